pipeline_perf_counter: RTL and testbench

- Synthesizable event-counter block for the pipelined CPU.
- Counts run cycles plus N_EVT pipeline event lines, such as stall, flush and instruction retire.
- Supports a programmable cycle limit and a registered readout port, so stall and flush statistics come from hardware rather than bench-side counting.
- Generalises the simple stall/flush tally:
  - parametrised channel count and counter width;
  - per-channel level or rising-edge counting mode;
  - saturation with sticky overflow flags;
  - automatic stop after MAX_CYCLES.

---
 rtl/pipeline_perf_counter.sv | 125 ++++++++++++
 tb/tb_pipeline_perf_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_perf_counter.sv
// Pipeline performance counter: a free-running cycle counter plus N_EVT
// event counters, gated by a run FSM with an optional cycle limit, each
// saturating with a sticky overflow flag, read through a registered mux.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i; nothing counts
// RUN     | counting while start_i=1, paused (holding) while start_i=0
// DONE    | cycle limit reached; counters frozen until clear or reset
module pipeline_perf_counter #(
    parameter int                 N_EVT      = 2,
    parameter int                 CNT_W      = 32,
    parameter int                 MAX_CYCLES = 30,
    parameter logic [N_EVT-1:0]   EDGE_MASK  = '0,
    parameter int                 SEL_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [N_EVT-1:0]  evt_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [N_EVT:0]    ovf_o,
    output logic              running_o,
    output logic              done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LP_SAT     = '1;
    localparam logic [CNT_W-1:0] LP_LAST    = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);
    localparam logic             LP_LIMITED = (MAX_CYCLES != 0);

    // Index N_EVT of r_cnt is the cycle counter; 0..N_EVT-1 are event channels.
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt [N_EVT+1];
    logic [N_EVT-1:0]  r_evt_prev;
    logic [CNT_W-1:0]  r_rd_data;
    logic [N_EVT:0]    r_ovf;

    logic              w_counting;
    logic              w_last;
    logic [N_EVT:0]    w_inc;
    logic [CNT_W-1:0]  w_rd_mux;

    assign w_counting = (r_state == ST_RUN) && start_i;
    assign w_last     = LP_LIMITED && (r_cnt[N_EVT] == LP_LAST);

    // Per-channel increment requests: level or rising-edge qualified.
    always_comb begin
        w_inc        = '0;
        w_inc[N_EVT] = w_counting;
        for (int k = 0; k < N_EVT; k++) begin
            if (EDGE_MASK[k]) begin
                w_inc[k] = w_counting && evt_i[k] && !r_evt_prev[k];
            end else begin
                w_inc[k] = w_counting && evt_i[k];
            end
        end
    end

    // Readout select; out-of-range selects return zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k <= N_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k)) begin
                w_rd_mux = r_cnt[k];
            end
        end
    end

    // Run-control FSM; clear behaves like reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i)                 r_state <= ST_RUN;
                ST_RUN:  if (w_counting && w_last)    r_state <= ST_DONE;
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating counters with sticky overflow, and the edge-detect history.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            for (int k = 0; k <= N_EVT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf      <= '0;
            r_evt_prev <= '0;
        end else begin
            r_evt_prev <= evt_i;
            for (int k = 0; k <= N_EVT; k++) begin
                if (w_inc[k]) begin
                    if (r_cnt[k] == LP_SAT) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Registered readout; clear does not touch it so it keeps tracking rd_sel_i.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data_o = r_rd_data;
    assign ovf_o     = r_ovf;
    assign running_o = (r_state == ST_RUN);
    assign done_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Bench for pipeline_perf_counter: two instances share one stimulus stream.
// Instance A uses defaults (32-bit, limit 30, level mode); instance B is
// 8-bit, unlimited, channel 1 in edge mode. A behavioural model tracks both.
module tb_pipeline_perf_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [1:0]  evt;
    logic [4:0]  sel;

    logic [31:0] a_rd;
    logic [2:0]  a_ovf;
    logic        a_running;
    logic        a_done;
    logic [7:0]  b_rd;
    logic [2:0]  b_ovf;
    logic        b_running;
    logic        b_done;

    int checks = 0;
    int errors = 0;

    pipeline_perf_counter #(
        .N_EVT(2), .CNT_W(32), .MAX_CYCLES(30), .EDGE_MASK(2'b00), .SEL_W(5)
    ) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
        .evt_i(evt), .rd_sel_i(sel), .rd_data_o(a_rd), .ovf_o(a_ovf),
        .running_o(a_running), .done_o(a_done)
    );

    pipeline_perf_counter #(
        .N_EVT(2), .CNT_W(8), .MAX_CYCLES(0), .EDGE_MASK(2'b10), .SEL_W(5)
    ) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
        .evt_i(evt), .rd_sel_i(sel), .rd_data_o(b_rd), .ovf_o(b_ovf),
        .running_o(b_running), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    longint   m_cnt  [2][3];
    bit       m_ovf  [2][3];
    bit [1:0] m_prev [2];
    longint   m_rd   [2];
    int       m_mode [2];
    longint   m_sat  [2];
    longint   m_lim  [2];
    bit [1:0] m_edge [2];

    task automatic model_zero(input int j);
        for (int c = 0; c < 3; c++) begin
            m_cnt[j][c] = 0;
            m_ovf[j][c] = 1'b0;
        end
        m_prev[j] = 2'b00;
        m_mode[j] = M_IDLE;
    endtask

    task automatic bump(input int j, input int c);
        if (m_cnt[j][c] == m_sat[j]) m_ovf[j][c] = 1'b1;
        else                         m_cnt[j][c] = m_cnt[j][c] + 1;
    endtask

    task automatic model_step(input int j);
        longint rdv;
        bit     hit;
        if (!rst_n) begin
            model_zero(j);
            m_rd[j] = 0;
        end else begin
            rdv = (sel <= 5'd2) ? m_cnt[j][int'(sel)] : 0;
            if (clear) begin
                model_zero(j);
            end else begin
                if (m_mode[j] == M_RUN && start) begin
                    for (int c = 0; c < 2; c++) begin
                        hit = m_edge[j][c] ? (evt[c] && !m_prev[j][c]) : evt[c];
                        if (hit) bump(j, c);
                    end
                    bump(j, 2);
                    if (m_lim[j] != 0 && m_cnt[j][2] == m_lim[j]) m_mode[j] = M_DONE;
                end else if (m_mode[j] == M_IDLE && start) begin
                    m_mode[j] = M_RUN;
                end
                m_prev[j] = evt;
            end
            m_rd[j] = rdv;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock with the current inputs and compare against the model.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("a_rd",      a_rd,      m_rd[0]);
        check("a_ovf",     a_ovf,     {m_ovf[0][2], m_ovf[0][1], m_ovf[0][0]});
        check("a_running", a_running, m_mode[0] == M_RUN);
        check("a_done",    a_done,    m_mode[0] == M_DONE);
        check("b_rd",      b_rd,      m_rd[1]);
        check("b_ovf",     b_ovf,     {m_ovf[1][2], m_ovf[1][1], m_ovf[1][0]});
        check("b_running", b_running, m_mode[1] == M_RUN);
        check("b_done",    b_done,    m_mode[1] == M_DONE);
    endtask

    typedef struct {
        logic [4:0] sel;
        logic [1:0] evt;
        longint     exp_data;
    } rd_vec_t;

    rd_vec_t vec [12];

    initial begin
        bit [8:0] pat;
        m_sat[0] = 64'd4294967295; m_lim[0] = 30; m_edge[0] = 2'b00;
        m_sat[1] = 255;            m_lim[1] = 0;  m_edge[1] = 2'b10;
        model_zero(0); model_zero(1);
        m_rd[0] = 0; m_rd[1] = 0;

        // Readout after the cycle limit: counts frozen at 4/2/30 whatever evt does.
        vec[0]  = '{5'd2,  2'b11, 30};
        vec[1]  = '{5'd0,  2'b11, 4};
        vec[2]  = '{5'd1,  2'b11, 2};
        vec[3]  = '{5'd3,  2'b11, 0};
        vec[4]  = '{5'd31, 2'b00, 0};
        vec[5]  = '{5'd2,  2'b01, 30};
        vec[6]  = '{5'd0,  2'b10, 4};
        vec[7]  = '{5'd1,  2'b11, 2};
        vec[8]  = '{5'd0,  2'b11, 4};
        vec[9]  = '{5'd2,  2'b11, 30};
        vec[10] = '{5'd1,  2'b00, 2};
        vec[11] = '{5'd7,  2'b11, 0};

        // Reset held with everything asserted.
        rst_n = 1'b0; start = 1'b1; clear = 1'b0; evt = 2'b11; sel = 5'd2;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_a_rd", a_rd, 0);
            check("rst_a_ovf", a_ovf, 0);
            check("rst_running", a_running | b_running, 0);
            check("rst_done", a_done | b_done, 0);
        end
        rst_n = 1'b1;
        tick();
        check("release_enters_run", a_running, 1);

        // Cycle limit: ch0 high on 4 run cycles, ch1 on 2.
        for (int i = 0; i < 30; i++) begin
            evt[0] = (i == 2 || i == 5 || i == 7 || i == 20);
            evt[1] = (i == 3 || i == 10);
            tick();
            if (i == 28) check("limit_not_yet_done", a_done, 0);
        end
        check("limit_done", a_done, 1);
        check("limit_not_running", a_running, 0);
        for (int i = 0; i < 12; i++) begin
            sel = vec[i].sel;
            evt = vec[i].evt;
            tick();
            check("frozen_readout", a_rd, vec[i].exp_data);
        end
        check("still_done", a_done, 1);

        // Clear mid-run at run cycle 12.
        clear = 1'b1; start = 1'b0; evt = 2'b00; tick();
        clear = 1'b0; start = 1'b1; tick();
        evt = 2'b01; sel = 5'd2;
        for (int i = 0; i < 11; i++) tick();
        clear = 1'b1;
        tick();
        check("clr_running", a_running | b_running, 0);
        check("clr_done", a_done | b_done, 0);
        check("clr_ovf", a_ovf | b_ovf, 0);
        check("clr_rd_kept", a_rd, 11);
        clear = 1'b0;
        tick();
        check("clr_reenter_run", a_running, 1);
        check("clr_cnt_zero", a_rd, 0);
        tick();
        tick();
        check("clr_restart_cnt", a_rd, 1);

        // Edge mode on B channel 1: 5 high, 1 low, 3 high.
        clear = 1'b1; start = 1'b0; evt = 2'b00; tick();
        clear = 1'b0; start = 1'b1; tick();
        pat = 9'b111011111;
        for (int i = 0; i < 9; i++) begin
            evt = {pat[i], pat[i]};
            tick();
        end
        start = 1'b0; evt = 2'b00;
        sel = 5'd1; tick();
        check("edge_b_ch1", b_rd, 2);
        check("level_a_ch1", a_rd, 8);
        sel = 5'd0; tick();
        check("level_b_ch0", b_rd, 8);
        sel = 5'd2; tick();
        check("edge_b_cycles", b_rd, 9);

        // Pause: 5 on, 7 off, 5 on.
        clear = 1'b1; tick();
        clear = 1'b0; start = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin
            start = (i < 5 || i >= 12);
            tick();
            check("pause_running", a_running, 1);
        end
        start = 1'b0; sel = 5'd2; tick();
        check("pause_a_cycles", a_rd, 10);
        check("pause_b_cycles", b_rd, 10);

        // Saturation on B channel 0 (8-bit, unlimited).
        clear = 1'b1; tick();
        clear = 1'b0; start = 1'b1; tick();
        evt = 2'b01;
        for (int i = 1; i <= 300; i++) begin
            tick();
            check("sat_ovf0", b_ovf[0], (i >= 256) ? 1 : 0);
            check("sat_ovf1", b_ovf[1], 0);
        end
        start = 1'b0; sel = 5'd0; tick();
        check("sat_count", b_rd, 255);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            clear = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 3) != 0);
            evt   = 2'($urandom);
            sel   = 5'($urandom_range(0, 7));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
